// File: rtl/ws281x_pkg.sv
// ws281x_pkg
// Shared types and widths for the WS281x frame sequencer.
//   - ws281x_state_t : sequencer state encoding
//   - TCNT_W         : width of the per-bit high/period timing counts
//   - LATCH_W        : width of the latch/reset gap count
// Optional feature macro: WS281X_LATCH_EN (adds the LATCH state).
package ws281x_pkg;

    localparam int TCNT_W  = 8;
    localparam int LATCH_W = 16;

`ifdef WS281X_LATCH_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } ws281x_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd5
    } ws281x_state_t;
`endif

endpackage : ws281x_pkg

// File: rtl/ws281x_bit_gen.sv
// ws281x_bit_gen
// Per-bit waveform timer. A bit_start_in strobe arms the timer for the next
// cycle: the high/period counts for the selected bit value are captured and the
// counter runs 0..period. The line is high while the counter is <= high count,
// so a high count at or above the period produces an all-high bit. A period
// count of 0 is promoted to 1 so every bit lasts at least two cycles.
//
// Ports
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   bit_start_in       arm a new bit starting next cycle
//   bit_val_in         value of that bit (selects t0*/t1* counts)
//   t0h_cnt_in ...     high cycles-1 / period cycles-1 for '0' and '1' bits
//   bit_out            LED data line
//   last_out           high in the final cycle of the current bit
module ws281x_bit_gen
    import ws281x_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              bit_start_in,
    input  logic              bit_val_in,
    input  logic [TCNT_W-1:0] t0h_cnt_in,
    input  logic [TCNT_W-1:0] t0s_cnt_in,
    input  logic [TCNT_W-1:0] t1h_cnt_in,
    input  logic [TCNT_W-1:0] t1s_cnt_in,
    output logic              bit_out,
    output logic              last_out
);

    logic              active_q;
    logic [TCNT_W-1:0] cnt_q;
    logic [TCNT_W-1:0] th_q;
    logic [TCNT_W-1:0] ts_q;

    logic [TCNT_W-1:0] sel_h;
    logic [TCNT_W-1:0] sel_s;
    logic [TCNT_W-1:0] sel_s_eff;

    assign sel_h     = bit_val_in ? t1h_cnt_in : t0h_cnt_in;
    assign sel_s     = bit_val_in ? t1s_cnt_in : t0s_cnt_in;
    assign sel_s_eff = (sel_s == '0) ? TCNT_W'(1) : sel_s;

    assign last_out = active_q && (cnt_q == ts_q);
    assign bit_out  = active_q && (cnt_q <= th_q);

    // A new start wins over the terminal count so consecutive bits abut.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            th_q     <= '0;
            ts_q     <= '0;
        end else if (bit_start_in) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            th_q     <= sel_h;
            ts_q     <= sel_s_eff;
        end else if (last_out) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q + TCNT_W'(1);
        end
    end

endmodule : ws281x_bit_gen

// File: rtl/ws281x_ctrl.sv
// ws281x_ctrl
// Frame sequencer for the WS281x output channel. A start strobe in IDLE reads
// byte_cnt_in bytes from the frame buffer RAM and shifts each out MSB-first
// through ws281x_bit_gen. The next byte is fetched during the last bit of the
// current one so the stream has no gaps. With WS281X_LATCH_EN defined, the
// line is then held low for rst_cnt_in+1 cycles before the done pulse.
//
// Ports
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   start_in               frame start, only sampled in IDLE
//   byte_cnt_in            frame length in bytes, latched at start
//   t0h/t0s/t1h/t1s_cnt_in bit timing counts (high-1 / period-1)
//   rst_cnt_in             latch gap cycles-1 (WS281X_LATCH_EN only)
//   rd_en_out, rd_addr_out RAM read strobe / address
//   rd_data_in             RAM data, valid the cycle after rd_en_out
//   bit_out                LED data line
//   busy_out               frame in progress
//   done_out               one-cycle frame-complete pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_in
// FETCH | read strobe for byte 0
// WAIT  | byte 0 arrives; arm first bit
// SEND  | shifting bits; prefetch next byte during bit 7
// LATCH | line held low for the latch gap (WS281X_LATCH_EN only)
// DONE  | done_out pulse, back to IDLE
module ws281x_ctrl
    import ws281x_pkg::*;
#(
    parameter int BYTE_CNT_WIDTH = 10
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [BYTE_CNT_WIDTH-1:0] byte_cnt_in,
    input  logic [TCNT_W-1:0]         t0h_cnt_in,
    input  logic [TCNT_W-1:0]         t0s_cnt_in,
    input  logic [TCNT_W-1:0]         t1h_cnt_in,
    input  logic [TCNT_W-1:0]         t1s_cnt_in,
`ifdef WS281X_LATCH_EN
    input  logic [LATCH_W-1:0]        rst_cnt_in,
`endif
    output logic                      rd_en_out,
    output logic [BYTE_CNT_WIDTH-1:0] rd_addr_out,
    input  logic [7:0]                rd_data_in,
    output logic                      bit_out,
    output logic                      busy_out,
    output logic                      done_out
);

    ws281x_state_t             state_q;
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q;
    logic [BYTE_CNT_WIDTH-1:0] byte_idx_q;
    logic [BYTE_CNT_WIDTH-1:0] byte_nxt_idx;
    logic [2:0]                bit_num_q;
    logic [6:0]                sh_q;
    logic [7:0]                nxt_q;
    logic                      pf_pend_q;
    logic                      first_q;
`ifdef WS281X_LATCH_EN
    logic [LATCH_W-1:0]        latch_cnt_q;
`endif

    logic       more_bytes;
    logic       prefetch;
    logic [7:0] next_byte;
    logic       bit_start;
    logic       bit_val;
    logic       bit_last;

    // byte_idx_q < byte_cnt_q <= 2^W-1, so the increment cannot wrap.
    assign byte_nxt_idx = byte_idx_q + BYTE_CNT_WIDTH'(1);
    assign more_bytes   = byte_nxt_idx < byte_cnt_q;

    // first_q marks the first cycle of each bit; bit_num 7 is the LSB.
    assign prefetch = (state_q == ST_SEND) && first_q && (bit_num_q == 3'd7) && more_bytes;

    assign rd_en_out   = (state_q == ST_FETCH) || prefetch;
    assign rd_addr_out = prefetch ? byte_nxt_idx : '0;

    // With a two-cycle LSB the prefetched data is still on the RAM bus when
    // the bit ends, so bypass the next-byte register in that case.
    assign next_byte = pf_pend_q ? rd_data_in : nxt_q;

    assign busy_out = (state_q != ST_IDLE);
    assign done_out = (state_q == ST_DONE);

    always_comb begin
        bit_start = 1'b0;
        bit_val   = 1'b0;
        if (state_q == ST_WAIT) begin
            bit_start = 1'b1;
            bit_val   = rd_data_in[7];
        end else if ((state_q == ST_SEND) && bit_last) begin
            if (bit_num_q != 3'd7) begin
                bit_start = 1'b1;
                bit_val   = sh_q[6];
            end else if (more_bytes) begin
                bit_start = 1'b1;
                bit_val   = next_byte[7];
            end
        end
    end

    ws281x_bit_gen u_bit_gen (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .bit_start_in (bit_start),
        .bit_val_in   (bit_val),
        .t0h_cnt_in   (t0h_cnt_in),
        .t0s_cnt_in   (t0s_cnt_in),
        .t1h_cnt_in   (t1h_cnt_in),
        .t1s_cnt_in   (t1s_cnt_in),
        .bit_out      (bit_out),
        .last_out     (bit_last)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            byte_idx_q  <= '0;
            bit_num_q   <= '0;
            sh_q        <= '0;
            nxt_q       <= '0;
            pf_pend_q   <= 1'b0;
            first_q     <= 1'b0;
`ifdef WS281X_LATCH_EN
            latch_cnt_q <= '0;
`endif
        end else begin
            first_q   <= bit_start;
            pf_pend_q <= prefetch;
            if (pf_pend_q) begin
                nxt_q <= rd_data_in;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        byte_cnt_q <= byte_cnt_in;
                        byte_idx_q <= '0;
                        if (byte_cnt_in != '0) begin
                            state_q <= ST_FETCH;
                        end else begin
`ifdef WS281X_LATCH_EN
                            latch_cnt_q <= rst_cnt_in;
                            state_q     <= ST_LATCH;
`else
                            state_q     <= ST_DONE;
`endif
                        end
                    end
                end

                ST_FETCH: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    sh_q      <= rd_data_in[6:0];
                    bit_num_q <= '0;
                    state_q   <= ST_SEND;
                end

                ST_SEND: begin
                    if (bit_last) begin
                        if (bit_num_q != 3'd7) begin
                            sh_q      <= {sh_q[5:0], 1'b0};
                            bit_num_q <= bit_num_q + 3'd1;
                        end else if (more_bytes) begin
                            sh_q       <= next_byte[6:0];
                            bit_num_q  <= '0;
                            byte_idx_q <= byte_nxt_idx;
                        end else begin
`ifdef WS281X_LATCH_EN
                            latch_cnt_q <= rst_cnt_in;
                            state_q     <= ST_LATCH;
`else
                            state_q     <= ST_DONE;
`endif
                        end
                    end
                end

`ifdef WS281X_LATCH_EN
                ST_LATCH: begin
                    if (latch_cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q - LATCH_W'(1);
                    end
                end
`endif

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ws281x_ctrl

// File: doc/ws281x_ctrl.md
# ws281x_ctrl

Frame sequencer for the WS281x output channel. On a start strobe it reads a frame of pixel bytes from the frame buffer RAM and serialises each byte MSB-first onto the LED data line, using the per-bit high/period timing counts. It prefetches the next byte so bits stay back-to-back, then optionally holds the latch/reset gap. It sits between the frame buffer and the output pin, and is driven by the host-side configuration registers.

## Interface
- BYTE_CNT_WIDTH, 10, width of byte count and RAM address (frames up to 2^BYTE_CNT_WIDTH-1 bytes)

- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  frame start strobe, sampled only in IDLE
- byte_cnt_in  input  BYTE_CNT_WIDTH  bytes in frame, latched at start
- t0h_cnt_in / t0s_cnt_in  input  8  '0' bit: high cycles-1 / period cycles-1
- t1h_cnt_in / t1s_cnt_in  input  8  '1' bit: high cycles-1 / period cycles-1
- rst_cnt_in  input  16  latch gap cycles-1 (only with WS281X_LATCH_EN)
- rd_en_out  output  1  RAM read strobe, one cycle
- rd_addr_out  output  BYTE_CNT_WIDTH  RAM byte address
- rd_data_in  input  8  RAM data, valid the cycle after rd_en_out
- bit_out  output  1  LED data line
- busy_out  output  1  frame in progress
- done_out  output  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, FETCH, WAIT, SEND, LATCH, DONE.
- IDLE, start_in=1:
  - byte_cnt_in!=0 → FETCH.
  - byte_cnt_in=0 → LATCH (no reads, no bits).
- FETCH: rd_en_out=1, rd_addr_out=0 → WAIT.
- WAIT: capture rd_data_in into shift register → SEND.
- SEND: per bit, latch the matching tXh/tXs at bit start; the counter runs 0..tXs.
  - bit_out=1 while cnt<=tXh, else 0.
  - tXh>=tXs gives an all-high bit.
  - tXs=0 is treated as 1, so the minimum period is 2 cycles.
- Prefetch: in the first cycle of bit 7 of byte k, if k+1<byte count, pulse rd_en_out with rd_addr_out=k+1. Capture the data next cycle into a next-byte register, then load it at the end of bit 7.
- After the last bit of the last byte → LATCH (bit_out=0).
- DONE: done_out=1 for one cycle, then IDLE.
- start_in outside IDLE is ignored. Inputs changing mid-frame affect only bits that start afterwards; byte count stays latched.

## Timing
- Reset values: bit_out=0, rd_en_out=0, rd_addr_out=0, busy_out=0, done_out=0, state IDLE.
- Reset mid-frame forces all outputs to these values immediately, because reset is asynchronous.
- Start sampled at edge E0 → FETCH cycle 1, WAIT cycle 2, first bit_out high from cycle 3.
- Bit period is tXs+1 cycles. High time is min(tXh,tXs)+1 cycles.
- No idle cycles between bits or bytes.
- busy_out is high from the cycle after start sampling through the DONE cycle inclusive.
- LATCH lasts rst_cnt_in+1 cycles. DONE follows immediately.

## Configuration
- WS281X_LATCH_EN defined: rst_cnt_in exists and the LATCH state holds bit_out low for rst_cnt_in+1 cycles before DONE.
- Undefined: the port and the LATCH state are absent. The last bit (or a zero-byte start) goes directly to DONE.

## Structure
- Shared package ws281x_pkg holds:
  - the state enum typedef;
  - the timing-count width constant (8);
  - the latch-count width constant (16).
- Sub-module ws281x_bit_gen contains the per-bit timer.
  - Inputs: bit start strobe, bit value, the four counts.
  - Outputs: bit_out, plus a last-cycle flag used by the sequencer.

## Test plan
- 1 byte 0xA5, t0h=3, t0s=9, t1h=6, t1s=9, rst=19 → eight 10-cycle bits; 1-bits high 7 cycles, 0-bits high 4, in order 1,0,1,0,0,1,0,1; then 20 low cycles; done_out one cycle; busy_out spans 3+80+20 cycles.
- 3 bytes 0xFF,0x00,0x81 → rd_addr_out 0,1,2, each with a one-cycle rd_en_out; the bit stream is continuous across byte boundaries; second and third reads occur in the first cycle of the previous byte's bit 7.
- byte_cnt_in=0, rst=4 → no rd_en_out, bit_out stays 0, done_out 6 cycles after start.
- t1h=12, t1s=5, t0s=0, t0h=0, byte 0x80 → first bit high all 6 cycles; remaining bits 2-cycle periods, high 1 cycle.
- start_in pulsed mid-frame → ignored, frame unchanged. rst_n_in low mid-bit → bit_out=0 and busy_out=0 immediately; a new start afterwards runs a clean frame from address 0.
- Macro undefined, 1 byte → done_out in the cycle after the last bit ends, with no latch gap.
